ulpi_phy_responder: RTL

ULPI_PHY_RESPONDER -- requirements
Module: ulpi_phy_responder

---
 rtl/ulpi_phy_responder.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ulpi_phy_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ulpi_phy_responder
// Brief    : Behavioural ULPI PHY responder. Accepts link TX CMDs (transmit,
//            register write, register read), forwards transmit packets on an
//            AXI-Stream master, and turns AXI-Stream slave packets and line
//            state changes into PHY-driven receive sequences.
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_phy_responder #(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
    input  logic       clock,
    input  logic       areset_n,
    output logic       ulpi_dir_o,
    output logic       ulpi_nxt_o,
    input  logic       ulpi_stp_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    input  logic [1:0] linestate_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    input  logic       s_axis_tlast_i,
    input  logic [7:0] s_axis_tdata_i,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       m_axis_tlast_o,
    output logic [7:0] m_axis_tdata_o,
    output logic [7:0] func_ctrl_o,
    output logic [7:0] otg_ctrl_o,
    output logic       phy_reset_o
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TX_ACK   = 4'd1,
        TX_DATA  = 4'd2,
        WR_DATA  = 4'd3,
        WR_STP   = 4'd4,
        RD_TURN  = 4'd5,
        RD_DATA  = 4'd6,
        RD_TURN2 = 4'd7,
        RX_TURN  = 4'd8,
        RX_CMD   = 4'd9,
        RX_DATA  = 4'd10,
        RX_END   = 4'd11,
        RX_TURN2 = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [5:0] r_addr;       // register address from the last TX CMD
    logic [7:0] r_wdata;      // register write data
    logic       r_acc;        // second cycle of WR_DATA / RD_TURN
    logic       r_rx_pkt;     // receive sequence carries a packet
    logic [1:0] r_ls_rep;     // last linestate reported to the link
    logic [7:0] r_buf;        // one-byte transmit holding buffer
    logic       r_buf_vld;
    logic       r_stp_seen;   // stp arrived while m_axis was still busy
    logic       r_m_vld;
    logic [7:0] r_m_data;
    logic       r_m_last;
    logic [7:0] r_func_ctrl;
    logic [7:0] r_otg_ctrl;
    logic       r_phy_reset;

    logic       w_take_cmd;
    logic       w_consume;
    logic       w_load;
    logic       w_load_last;
    logic       w_commit;
    logic       w_m_free;
    logic [7:0] w_rd_data;
    logic [7:0] w_rxcmd_act;
    logic [7:0] w_rxcmd_idle;

    assign w_m_free     = !r_m_vld || m_axis_tready_i;
    assign w_rxcmd_act  = {2'b00, 2'b01, 2'b11, linestate_i};
    assign w_rxcmd_idle = {2'b00, 2'b00, 2'b11, linestate_i};

    assign m_axis_tvalid_o = r_m_vld;
    assign m_axis_tdata_o  = r_m_data;
    assign m_axis_tlast_o  = r_m_last;
    assign func_ctrl_o     = r_func_ctrl;
    assign otg_ctrl_o      = r_otg_ctrl;
    assign phy_reset_o     = r_phy_reset;

    // Register read-back mux; set/clear aliases read the underlying register.
    always_comb begin
        w_rd_data = 8'h00;
        case (r_addr)
            6'h00:               w_rd_data = VENDOR_ID[7:0];
            6'h01:               w_rd_data = VENDOR_ID[15:8];
            6'h02:               w_rd_data = PRODUCT_ID[7:0];
            6'h03:               w_rd_data = PRODUCT_ID[15:8];
            6'h04, 6'h05, 6'h06: w_rd_data = r_func_ctrl;
            6'h0A, 6'h0B, 6'h0C: w_rd_data = r_otg_ctrl;
            default:             w_rd_data = 8'h00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // FSM next state, bus outputs and datapath strobes.
    always_comb begin
        w_state_nxt     = r_state;
        ulpi_dir_o      = 1'b0;
        ulpi_nxt_o      = 1'b0;
        ulpi_data_o     = 8'h00;
        s_axis_tready_o = 1'b0;
        w_take_cmd      = 1'b0;
        w_consume       = 1'b0;
        w_load          = 1'b0;
        w_load_last     = 1'b0;
        w_commit        = 1'b0;
        case (r_state)
            IDLE: begin
                // PHY events win; a losing TX CMD stays on the bus untouched.
                if (s_axis_tvalid_i || (linestate_i != r_ls_rep)) begin
                    w_state_nxt = RX_TURN;
                end else if (ulpi_data_i[7:6] != 2'b00) begin
                    w_take_cmd = 1'b1;
                    case (ulpi_data_i[7:6])
                        2'b01:   w_state_nxt = TX_ACK;
                        2'b10:   w_state_nxt = WR_DATA;
                        default: w_state_nxt = RD_TURN;
                    endcase
                end
            end
            TX_ACK: begin
                ulpi_nxt_o  = 1'b1;
                w_consume   = 1'b1;
                w_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (ulpi_stp_i || r_stp_seen) begin
                    // Flush the buffered byte as the packet's last beat.
                    if (w_m_free) begin
                        w_load      = 1'b1;
                        w_load_last = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    ulpi_nxt_o = !(r_buf_vld && !m_axis_tready_i);
                    w_consume  = ulpi_nxt_o;
                    w_load     = ulpi_nxt_o && r_buf_vld;
                end
            end
            WR_DATA: begin
                ulpi_nxt_o = 1'b1;
                if (r_acc) w_state_nxt = WR_STP;
            end
            WR_STP: begin
                if (ulpi_stp_i) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            RD_TURN: begin
                if (!r_acc) begin
                    ulpi_nxt_o = 1'b1;
                end else begin
                    ulpi_dir_o  = 1'b1;
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                ulpi_dir_o  = 1'b1;
                ulpi_data_o = w_rd_data;
                w_state_nxt = RD_TURN2;
            end
            RD_TURN2: w_state_nxt = IDLE;
            RX_TURN: begin
                ulpi_dir_o  = 1'b1;
                w_state_nxt = r_rx_pkt ? RX_CMD : RX_END;
            end
            RX_CMD: begin
                ulpi_dir_o  = 1'b1;
                ulpi_data_o = w_rxcmd_act;
                w_state_nxt = RX_DATA;
            end
            RX_DATA: begin
                ulpi_dir_o = 1'b1;
                if (s_axis_tvalid_i) begin
                    ulpi_data_o     = s_axis_tdata_i;
                    ulpi_nxt_o      = 1'b1;
                    s_axis_tready_o = 1'b1;
                    if (s_axis_tlast_i) w_state_nxt = RX_END;
                end else begin
                    ulpi_data_o = w_rxcmd_act;
                end
            end
            RX_END: begin
                ulpi_dir_o  = 1'b1;
                ulpi_data_o = w_rxcmd_idle;
                w_state_nxt = RX_TURN2;
            end
            RX_TURN2: w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Command bookkeeping: address, write data, phase flag, reported linestate.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            r_addr   <= 6'h00;
            r_wdata  <= 8'h00;
            r_acc    <= 1'b0;
            r_rx_pkt <= 1'b0;
            r_ls_rep <= 2'b01;
        end else begin
            if (w_take_cmd) r_addr <= ulpi_data_i[5:0];
            if ((r_state == WR_DATA) && r_acc) r_wdata <= ulpi_data_i;
            r_acc <= ((r_state == WR_DATA) || (r_state == RD_TURN)) && !r_acc;
            if (r_state == IDLE) r_rx_pkt <= s_axis_tvalid_i;
            if (r_state == RX_END) r_ls_rep <= linestate_i;
        end
    end

    // Transmit path: holding buffer feeding the m_axis output stage.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            r_buf      <= 8'h00;
            r_buf_vld  <= 1'b0;
            r_stp_seen <= 1'b0;
            r_m_vld    <= 1'b0;
            r_m_data   <= 8'h00;
            r_m_last   <= 1'b0;
        end else begin
            if (w_consume) begin
                r_buf     <= (r_state == TX_ACK) ? {4'h0, ulpi_data_i[3:0]} : ulpi_data_i;
                r_buf_vld <= 1'b1;
            end
            if (w_load_last) begin
                r_buf_vld  <= 1'b0;
                r_stp_seen <= 1'b0;
            end else if ((r_state == TX_DATA) && ulpi_stp_i) begin
                r_stp_seen <= 1'b1;
            end
            if (w_load) begin
                r_m_vld  <= 1'b1;
                r_m_data <= r_buf;
                r_m_last <= w_load_last;
            end else if (m_axis_tready_i) begin
                r_m_vld <= 1'b0;
            end
        end
    end

    // Control registers: committed writes and the self-clearing reset bit.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            r_func_ctrl <= 8'h41;
            r_otg_ctrl  <= 8'h06;
            r_phy_reset <= 1'b0;
        end else begin
            r_phy_reset <= r_func_ctrl[5];
            if (r_func_ctrl[5]) r_func_ctrl[5] <= 1'b0;
            if (w_commit) begin
                case (r_addr)
                    6'h04:   r_func_ctrl <= r_wdata;
                    6'h05:   r_func_ctrl <= r_func_ctrl | r_wdata;
                    6'h06:   r_func_ctrl <= r_func_ctrl & ~r_wdata;
                    6'h0A:   r_otg_ctrl  <= r_wdata;
                    6'h0B:   r_otg_ctrl  <= r_otg_ctrl | r_wdata;
                    6'h0C:   r_otg_ctrl  <= r_otg_ctrl & ~r_wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
